bw_r_irf_swap_ctl: RTL and testbench

Window-swap sequencer for the integer register file window save/restore datapath. Takes per-thread window-change requests (old CWP, new CWP) from four hardware threads and arbitrates them round-robin. It drives the shared save/restore command interface of every window register: a save to {tid, old_cwp}, then a restore from {tid, new_cwp}. It stalls the requesting thread until the swap is acknowledged.

---
 rtl/bw_r_irf_swap_ctl.sv | 138 +++++++++++++
 tb/tb_bw_r_irf_swap_ctl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bw_r_irf_swap_ctl.sv
// Window-swap sequencer: arbitrates per-thread CWP change requests round-robin and
// issues one save {tid,old_cwp} followed by one restore {tid,new_cwp} per swap.
module bw_r_irf_swap_ctl #(
  parameter int WIN_W    = 3,
  parameter int SAVE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [3:0]           swap_req,
  input  logic [4*WIN_W-1:0]   swap_old_cwp,
  input  logic [4*WIN_W-1:0]   swap_new_cwp,
  output logic [3:0]           swap_busy,
  output logic [3:0]           swap_ack,
  output logic [3:0]           swap_err,
  output logic                 save,
  output logic [2+WIN_W-1:0]   save_addr,
  output logic                 restore,
  output logic [2+WIN_W-1:0]   rd_addr,
  output logic [2+WIN_W-1:0]   wr_addr
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RESTORE = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  // Handshake: swap_req[i] is a single-cycle request, accepted when swap_busy[i]
  // is low or swap_ack[i] is high that cycle; otherwise it is dropped and
  // swap_err[i] pulses the following cycle. swap_busy[i] stays high until the
  // cycle after swap_ack[i].
  logic [2:0]       state;
  logic [3:0]       pending;
  logic [3:0]       err_q;
  logic [1:0]       rr;
  logic [1:0]       tid;
  logic [2:0]       wait_cnt;
  logic [WIN_W-1:0] old_slot [4];
  logic [WIN_W-1:0] new_slot [4];

  logic [3:0]       ack_vec;
  logic [3:0]       accept;
  logic [3:0]       reject;
  logic             grant_vld;
  logic [1:0]       grant_tid;
  logic [1:0]       scan_idx;
  logic [2+WIN_W-1:0] restore_addr;

  assign ack_vec      = (state == ST_ACK) ? (4'b0001 << tid) : 4'b0000;
  assign accept       = swap_req & (~pending | ack_vec);
  assign reject       = swap_req & pending & ~ack_vec;
  assign restore_addr = {tid, new_slot[tid]};

  // Scan from the highest offset down so the thread closest to rr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_tid = rr;
    scan_idx  = rr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr + 2'(k);
      if (pending[scan_idx]) begin
        grant_vld = 1'b1;
        grant_tid = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= ST_IDLE;
      pending   <= 4'b0000;
      err_q     <= 4'b0000;
      rr        <= 2'd0;
      tid       <= 2'd0;
      wait_cnt  <= 3'd0;
      save_addr <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      for (int i = 0; i < 4; i++) begin
        old_slot[i] <= '0;
        new_slot[i] <= '0;
      end
    end else begin
      err_q   <= reject;
      pending <= (pending & ~ack_vec) | accept;
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          old_slot[i] <= swap_old_cwp[i*WIN_W +: WIN_W];
          new_slot[i] <= swap_new_cwp[i*WIN_W +: WIN_W];
        end
      end

      case (state)
        ST_IDLE: begin
          // Only reached with nothing in flight, so every pending thread is ungranted.
          if (grant_vld) begin
            tid <= grant_tid;
            rr  <= grant_tid + 2'd1;
            if (old_slot[grant_tid] != new_slot[grant_tid]) begin
              state     <= ST_SAVE;
              save_addr <= {grant_tid, old_slot[grant_tid]};
              wr_addr   <= {grant_tid, old_slot[grant_tid]};
            end else begin
              state <= ST_ACK;
            end
          end
        end
        ST_SAVE: begin
          if (SAVE_LAT > 1) begin
            state    <= ST_WAIT;
            wait_cnt <= 3'(SAVE_LAT - 1);
          end else begin
            state   <= ST_RESTORE;
            rd_addr <= restore_addr;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 3'd1) begin
            state   <= ST_RESTORE;
            rd_addr <= restore_addr;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESTORE: state <= ST_ACK;
        ST_ACK:     state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign swap_busy = pending;
  assign swap_ack  = ack_vec;
  assign swap_err  = err_q;
  assign save      = (state == ST_SAVE);
  assign restore   = (state == ST_RESTORE);

endmodule

// File: tb/tb_bw_r_irf_swap_ctl.sv
// Directed bench for bw_r_irf_swap_ctl: one instance with SAVE_LAT=1 and one with
// SAVE_LAT=4, each driven with hand-computed cycle-exact expectations.
module tb_bw_r_irf_swap_ctl;

  logic        clk;
  int          errors;
  int          checks;

  logic        rst1, rst4;
  logic [3:0]  req1, req4;
  logic [11:0] old1, new1, old4, new4;
  logic [3:0]  busy1, ack1, err1, busy4, ack4, err4;
  logic        save1, restore1, save4, restore4;
  logic [4:0]  save_addr1, rd_addr1, wr_addr1, save_addr4, rd_addr4, wr_addr4;

  bw_r_irf_swap_ctl #(.WIN_W(3), .SAVE_LAT(1)) dut1 (
    .clk(clk), .rst_l(rst1), .swap_req(req1), .swap_old_cwp(old1), .swap_new_cwp(new1),
    .swap_busy(busy1), .swap_ack(ack1), .swap_err(err1), .save(save1), .save_addr(save_addr1),
    .restore(restore1), .rd_addr(rd_addr1), .wr_addr(wr_addr1)
  );

  bw_r_irf_swap_ctl #(.WIN_W(3), .SAVE_LAT(4)) dut4 (
    .clk(clk), .rst_l(rst4), .swap_req(req4), .swap_old_cwp(old4), .swap_new_cwp(new4),
    .swap_busy(busy4), .swap_ack(ack4), .swap_err(err4), .save(save4), .save_addr(save_addr4),
    .restore(restore4), .rd_addr(rd_addr4), .wr_addr(wr_addr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset1();
    rst1 = 1'b0; req1 = '0; old1 = '0; new1 = '0;
    tick(); tick();
    rst1 = 1'b1;
  endtask

  task automatic test_reset();
    rst1 = 1'b0; rst4 = 1'b0;
    req1 = '0; old1 = '0; new1 = '0; req4 = '0; old4 = '0; new4 = '0;
    tick(); tick();
    checks++;
    if ({busy1, ack1, err1, save1, restore1, save_addr1, rd_addr1, wr_addr1} !== 29'd0) begin
      errors++; $display("FAIL reset_dut1 got=%h exp=0", {busy1, ack1, err1, save1, restore1, save_addr1, rd_addr1, wr_addr1});
    end
    checks++;
    if ({busy4, ack4, err4, save4, restore4, save_addr4, rd_addr4, wr_addr4} !== 29'd0) begin
      errors++; $display("FAIL reset_dut4 got=%h exp=0", {busy4, ack4, err4, save4, restore4, save_addr4, rd_addr4, wr_addr4});
    end
    rst1 = 1'b1; rst4 = 1'b1;
  endtask

  task automatic test_single();
    req1 = 4'b0100; old1 = '0; new1 = '0; old1[6 +: 3] = 3'd3; new1[6 +: 3] = 3'd4;
    tick(); req1 = '0;
    checks++; if (busy1 !== 4'b0100 || save1 !== 1'b0) begin errors++; $display("FAIL single_c1 busy=%b save=%b exp busy=0100 save=0", busy1, save1); end
    tick();
    checks++; if (save1 !== 1'b1 || save_addr1 !== 5'b10011 || restore1 !== 1'b0) begin errors++; $display("FAIL single_save save=%b addr=%b restore=%b exp 1/10011/0", save1, save_addr1, restore1); end
    tick();
    checks++; if (restore1 !== 1'b1 || rd_addr1 !== 5'b10100 || wr_addr1 !== 5'b10011 || save1 !== 1'b0) begin errors++; $display("FAIL single_restore restore=%b rd=%b wr=%b save=%b exp 1/10100/10011/0", restore1, rd_addr1, wr_addr1, save1); end
    tick();
    checks++; if (ack1 !== 4'b0100 || busy1 !== 4'b0100 || restore1 !== 1'b0) begin errors++; $display("FAIL single_ack ack=%b busy=%b restore=%b exp 0100/0100/0", ack1, busy1, restore1); end
    tick();
    checks++; if (busy1 !== 4'b0000 || ack1 !== 4'b0000) begin errors++; $display("FAIL single_done busy=%b ack=%b exp 0000/0000", busy1, ack1); end
    checks++; if (save_addr1 !== 5'b10011 || rd_addr1 !== 5'b10100 || wr_addr1 !== 5'b10011) begin errors++; $display("FAIL single_hold save_addr=%b rd=%b wr=%b exp 10011/10100/10011", save_addr1, rd_addr1, wr_addr1); end
  endtask

  task automatic test_same_window();
    req1 = 4'b0010; old1 = '0; new1 = '0; old1[3 +: 3] = 3'd6; new1[3 +: 3] = 3'd6;
    tick(); req1 = '0;
    checks++; if (busy1 !== 4'b0010 || save1 !== 1'b0 || restore1 !== 1'b0) begin errors++; $display("FAIL same_c1 busy=%b save=%b restore=%b exp 0010/0/0", busy1, save1, restore1); end
    tick();
    checks++; if (ack1 !== 4'b0010 || save1 !== 1'b0 || restore1 !== 1'b0) begin errors++; $display("FAIL same_ack ack=%b save=%b restore=%b exp 0010/0/0", ack1, save1, restore1); end
    tick();
    checks++; if (busy1 !== 4'b0000 || save1 !== 1'b0 || restore1 !== 1'b0) begin errors++; $display("FAIL same_done busy=%b save=%b restore=%b exp 0000/0/0", busy1, save1, restore1); end
    tick();
  endtask

  task automatic test_contention();
    logic       exp_save, exp_rest;
    logic [3:0] exp_ack;
    logic [1:0] t;
    do_reset1();
    req1 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      old1[i*3 +: 3] = 3'(i);
      new1[i*3 +: 3] = 3'(i + 4);
    end
    tick(); req1 = '0;
    checks++; if (busy1 !== 4'b1111) begin errors++; $display("FAIL cont_busy got=%b exp=1111", busy1); end
    for (int c = 1; c <= 17; c++) begin
      exp_save = (c >= 2 && c <= 14 && (c - 2) % 4 == 0);
      exp_rest = (c >= 3 && c <= 15 && (c - 3) % 4 == 0);
      exp_ack  = (c >= 4 && c <= 16 && c % 4 == 0) ? (4'b0001 << ((c - 4) / 4)) : 4'b0000;
      checks++; if (save1 !== exp_save || restore1 !== exp_rest || ack1 !== exp_ack) begin
        errors++; $display("FAIL cont_c%0d save=%b restore=%b ack=%b exp %b/%b/%b", c, save1, restore1, ack1, exp_save, exp_rest, exp_ack);
      end
      if (exp_save) begin
        t = 2'((c - 2) / 4);
        checks++; if (save_addr1 !== {t, 1'b0, t}) begin errors++; $display("FAIL cont_save_addr_c%0d got=%b exp=%b", c, save_addr1, {t, 1'b0, t}); end
      end
      if (exp_rest) begin
        t = 2'((c - 3) / 4);
        checks++; if (rd_addr1 !== {t, 1'b1, t} || wr_addr1 !== {t, 1'b0, t}) begin errors++; $display("FAIL cont_rest_addr_c%0d rd=%b wr=%b exp %b/%b", c, rd_addr1, wr_addr1, {t, 1'b1, t}, {t, 1'b0, t}); end
      end
      tick();
    end
    checks++; if (busy1 !== 4'b0000) begin errors++; $display("FAIL cont_done busy=%b exp=0000", busy1); end
  endtask

  task automatic test_duplicate();
    req1 = 4'b1000; old1 = '0; new1 = '0; old1[9 +: 3] = 3'd5; new1[9 +: 3] = 3'd2;
    tick();
    old1[9 +: 3] = 3'd7; new1[9 +: 3] = 3'd0;
    checks++; if (busy1 !== 4'b1000 || err1 !== 4'b0000) begin errors++; $display("FAIL dup_c1 busy=%b err=%b exp 1000/0000", busy1, err1); end
    tick(); req1 = '0;
    checks++; if (err1 !== 4'b1000 || save1 !== 1'b1 || save_addr1 !== 5'b11101) begin errors++; $display("FAIL dup_c2 err=%b save=%b addr=%b exp 1000/1/11101", err1, save1, save_addr1); end
    tick();
    checks++; if (err1 !== 4'b0000 || restore1 !== 1'b1 || rd_addr1 !== 5'b11010 || wr_addr1 !== 5'b11101) begin errors++; $display("FAIL dup_c3 err=%b restore=%b rd=%b wr=%b exp 0000/1/11010/11101", err1, restore1, rd_addr1, wr_addr1); end
    tick();
    checks++; if (ack1 !== 4'b1000) begin errors++; $display("FAIL dup_ack got=%b exp=1000", ack1); end
    tick();
    checks++; if (busy1 !== 4'b0000 || save1 !== 1'b0) begin errors++; $display("FAIL dup_done busy=%b save=%b exp 0000/0", busy1, save1); end
    tick();
  endtask

  task automatic test_back_to_back();
    req1 = 4'b0001; old1 = '0; new1 = '0; old1[0 +: 3] = 3'd3; new1[0 +: 3] = 3'd5;
    tick(); req1 = '0;
    tick(); tick(); tick();
    checks++; if (ack1 !== 4'b0001) begin errors++; $display("FAIL b2b_ack1 got=%b exp=0001", ack1); end
    req1 = 4'b0001; old1[0 +: 3] = 3'd1; new1[0 +: 3] = 3'd2;
    tick(); req1 = '0;
    checks++; if (busy1 !== 4'b0001 || err1 !== 4'b0000 || save1 !== 1'b0) begin errors++; $display("FAIL b2b_c5 busy=%b err=%b save=%b exp 0001/0000/0", busy1, err1, save1); end
    tick();
    checks++; if (save1 !== 1'b1 || save_addr1 !== 5'b00001) begin errors++; $display("FAIL b2b_save save=%b addr=%b exp 1/00001", save1, save_addr1); end
    tick();
    checks++; if (restore1 !== 1'b1 || rd_addr1 !== 5'b00010 || wr_addr1 !== 5'b00001) begin errors++; $display("FAIL b2b_restore restore=%b rd=%b wr=%b exp 1/00010/00001", restore1, rd_addr1, wr_addr1); end
    tick();
    checks++; if (ack1 !== 4'b0001) begin errors++; $display("FAIL b2b_ack2 got=%b exp=0001", ack1); end
    tick();
    checks++; if (busy1 !== 4'b0000) begin errors++; $display("FAIL b2b_done busy=%b exp=0000", busy1); end
  endtask

  // Runs one swap on the SAVE_LAT=4 instance and checks every cycle from 1 to 8.
  task automatic run_lat4_swap(input logic [1:0] t, input logic [2:0] o, input logic [2:0] n, input string tag);
    logic       exp_save, exp_rest;
    logic [3:0] exp_ack, exp_busy;
    req4 = 4'b0001 << t; old4 = '0; new4 = '0; old4[t*3 +: 3] = o; new4[t*3 +: 3] = n;
    tick(); req4 = '0;
    for (int c = 1; c <= 8; c++) begin
      exp_save = (c == 2);
      exp_rest = (c == 6);
      exp_ack  = (c == 7) ? (4'b0001 << t) : 4'b0000;
      exp_busy = (c <= 7) ? (4'b0001 << t) : 4'b0000;
      checks++; if (save4 !== exp_save || restore4 !== exp_rest || ack4 !== exp_ack || busy4 !== exp_busy) begin
        errors++; $display("FAIL %s_c%0d save=%b restore=%b ack=%b busy=%b exp %b/%b/%b/%b", tag, c, save4, restore4, ack4, busy4, exp_save, exp_rest, exp_ack, exp_busy);
      end
      if (c == 2) begin
        checks++; if (save_addr4 !== {t, o}) begin errors++; $display("FAIL %s_save_addr got=%b exp=%b", tag, save_addr4, {t, o}); end
      end
      if (c == 6) begin
        checks++; if (rd_addr4 !== {t, n} || wr_addr4 !== {t, o}) begin errors++; $display("FAIL %s_rest_addr rd=%b wr=%b exp %b/%b", tag, rd_addr4, wr_addr4, {t, n}, {t, o}); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_swap();
    run_lat4_swap(2'd1, 3'd0, 3'd7, "lat4");
    req4 = 4'b0010; old4 = '0; new4 = '0; old4[3 +: 3] = 3'd2; new4[3 +: 3] = 3'd5;
    tick(); req4 = '0;
    tick();
    checks++; if (save4 !== 1'b1 || save_addr4 !== 5'b01010) begin errors++; $display("FAIL mid_save save=%b addr=%b exp 1/01010", save4, save_addr4); end
    tick();
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    checks++;
    if ({busy4, ack4, err4, save4, restore4, save_addr4, rd_addr4, wr_addr4} !== 29'd0) begin
      errors++; $display("FAIL mid_reset got=%h exp=0", {busy4, ack4, err4, save4, restore4, save_addr4, rd_addr4, wr_addr4});
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (ack4 !== 4'b0000 || busy4 !== 4'b0000 || restore4 !== 1'b0) begin errors++; $display("FAIL mid_quiet_c%0d ack=%b busy=%b restore=%b exp 0000/0000/0", c, ack4, busy4, restore4); end
    end
    run_lat4_swap(2'd2, 3'd1, 3'd3, "post_rst");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_same_window();
    test_contention();
    test_duplicate();
    test_back_to_back();
    test_reset_mid_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
